// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-port data memory between the CPU datapath and a
// debug/loader port. CPU has priority; starvation and burst counters bound the waits.
module mem_arbiter #(
    parameter logic [3:0] STARVE_MAX = 4'd4,
    parameter logic [3:0] BURST_MAX  = 4'd4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       cpu_rd_i,
    input  logic       cpu_wr_i,
    input  logic [7:0] cpu_addr_i,
    input  logic [7:0] cpu_wdata_i,
    output logic       cpu_stall_o,
    output logic [7:0] cpu_rdata_o,
    output logic       cpu_rvalid_o,
    input  logic       dbg_req_i,
    input  logic       dbg_we_i,
    input  logic       dbg_lock_i,
    input  logic [7:0] dbg_addr_i,
    input  logic [7:0] dbg_wdata_i,
    output logic       dbg_gnt_o,
    output logic [7:0] dbg_rdata_o,
    output logic       dbg_rvalid_o,
    output logic [7:0] mem_addr_o,
    output logic [7:0] mem_wdata_o,
    output logic       mem_wren_o,
    output logic       mem_rden_o,
    input  logic [7:0] mem_q_i
);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2,
        OWN_LOCK = 2'd3
    } owner_e;

    owner_e     owner_q, owner_d;
    logic [3:0] starve_q, starve_d;
    logic [3:0] burst_q, burst_d;
    logic       rd_pend_q, rd_pend_d;
    logic       rd_who_q, rd_who_d;
    logic [7:0] cpu_rdata_q, cpu_rdata_d;
    logic [7:0] dbg_rdata_q, dbg_rdata_d;

    logic       cpu_req_s;
    logic       cpu_is_wr_s;
    logic       gnt_cpu_s;
    logic       gnt_dbg_s;
    logic       cpu_rvalid_s;
    logic       dbg_rvalid_s;

    function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] limit);
        if (value >= limit) begin
            return limit;
        end else begin
            return value + 4'd1;
        end
    endfunction

    // Both strobes high is treated as a write.
    assign cpu_req_s   = cpu_rd_i | cpu_wr_i;
    assign cpu_is_wr_s = cpu_wr_i;

    // Grant decision: locked debug burst, then CPU under the starvation bound, then debug, then CPU.
    always_comb begin
        gnt_cpu_s = 1'b0;
        gnt_dbg_s = 1'b0;
        if (reset_i) begin
            gnt_cpu_s = 1'b0;
            gnt_dbg_s = 1'b0;
        end else if ((owner_q == OWN_LOCK) && dbg_req_i && (burst_q < BURST_MAX)) begin
            gnt_dbg_s = 1'b1;
        end else if (cpu_req_s && (starve_q < STARVE_MAX)) begin
            gnt_cpu_s = 1'b1;
        end else if (dbg_req_i) begin
            gnt_dbg_s = 1'b1;
        end else if (cpu_req_s) begin
            gnt_cpu_s = 1'b1;
        end else begin
            gnt_cpu_s = 1'b0;
            gnt_dbg_s = 1'b0;
        end
    end

    // Memory port mux: steer the grantee's request, quiet bus otherwise.
    always_comb begin
        mem_addr_o  = 8'h00;
        mem_wdata_o = 8'h00;
        mem_wren_o  = 1'b0;
        mem_rden_o  = 1'b0;
        case ({gnt_dbg_s, gnt_cpu_s})
            2'b01: begin
                mem_addr_o  = cpu_addr_i;
                mem_wdata_o = cpu_wdata_i;
                mem_wren_o  = cpu_is_wr_s;
                mem_rden_o  = ~cpu_is_wr_s;
            end
            2'b10: begin
                mem_addr_o  = dbg_addr_i;
                mem_wdata_o = dbg_wdata_i;
                mem_wren_o  = dbg_we_i;
                mem_rden_o  = ~dbg_we_i;
            end
            default: begin
                mem_addr_o  = 8'h00;
                mem_wdata_o = 8'h00;
                mem_wren_o  = 1'b0;
                mem_rden_o  = 1'b0;
            end
        endcase
    end

    assign cpu_stall_o = cpu_req_s & ~gnt_cpu_s & ~reset_i;
    assign dbg_gnt_o   = gnt_dbg_s;

    // Next owner, fairness counters and read-return tag.
    always_comb begin
        owner_d   = OWN_IDLE;
        starve_d  = starve_q;
        burst_d   = burst_q;
        rd_pend_d = 1'b0;
        rd_who_d  = rd_who_q;

        if (gnt_dbg_s) begin
            owner_d   = dbg_lock_i ? OWN_LOCK : OWN_DBG;
            rd_pend_d = ~dbg_we_i;
            rd_who_d  = 1'b1;
        end else if (gnt_cpu_s) begin
            owner_d   = OWN_CPU;
            rd_pend_d = ~cpu_is_wr_s;
            rd_who_d  = 1'b0;
        end else begin
            owner_d   = OWN_IDLE;
            rd_pend_d = 1'b0;
        end

        if (gnt_dbg_s || !dbg_req_i) begin
            starve_d = 4'd0;
        end else if (gnt_cpu_s) begin
            starve_d = sat_inc(starve_q, STARVE_MAX);
        end else begin
            starve_d = starve_q;
        end

        // Reaching BURST_MAX makes the lock check fail once, letting the CPU in.
        if (gnt_cpu_s || !cpu_req_s) begin
            burst_d = 4'd0;
        end else if (gnt_dbg_s) begin
            burst_d = sat_inc(burst_q, BURST_MAX);
        end else begin
            burst_d = burst_q;
        end
    end

    // A return arriving while reset is high is dropped; rdata otherwise holds its last value.
    always_comb begin
        cpu_rvalid_s = rd_pend_q & ~rd_who_q & ~reset_i;
        dbg_rvalid_s = rd_pend_q &  rd_who_q & ~reset_i;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        if (cpu_rvalid_s) begin
            cpu_rdata_d = mem_q_i;
        end else begin
            cpu_rdata_d = cpu_rdata_q;
        end
        if (dbg_rvalid_s) begin
            dbg_rdata_d = mem_q_i;
        end else begin
            dbg_rdata_d = dbg_rdata_q;
        end
    end

    assign cpu_rvalid_o = cpu_rvalid_s;
    assign dbg_rvalid_o = dbg_rvalid_s;
    assign cpu_rdata_o  = cpu_rdata_d;
    assign dbg_rdata_o  = dbg_rdata_d;

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            owner_q     <= OWN_IDLE;
            starve_q    <= 4'd0;
            burst_q     <= 4'd0;
            rd_pend_q   <= 1'b0;
            rd_who_q    <= 1'b0;
            cpu_rdata_q <= 8'h00;
            dbg_rdata_q <= 8'h00;
        end else begin
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            burst_q     <= burst_d;
            rd_pend_q   <= rd_pend_d;
            rd_who_q    <= rd_who_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

endmodule
